// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: round-robin ARP/IP transmit arbiter in front of the MAC framer.
// One frame in flight; the forwarded byte count is policed against the granted length.
module mac_tx_arbiter #(
  parameter int P_GAP     = 4,
  parameter int P_TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_arp_req,
  input  logic [15:0] i_arp_len,
  output logic        o_arp_grant,
  input  logic [7:0]  i_arp_data,
  input  logic        i_arp_valid,
  input  logic        i_arp_last,
  input  logic        i_ip_req,
  input  logic [15:0] i_ip_len,
  output logic        o_ip_grant,
  input  logic [7:0]  i_ip_data,
  input  logic        i_ip_valid,
  input  logic        i_ip_last,
  output logic        o_mac_req,
  input  logic        i_mac_ready,
  output logic [15:0] o_send_type,
  output logic [15:0] o_send_len,
  output logic [7:0]  o_send_data,
  output logic        o_send_valid,
  output logic        o_send_last,
  output logic        o_len_err,
  output logic        o_timeout
);
  // state | meaning
  // IDLE  | waiting for framer ready and a request
  // WAIT  | grant issued, waiting for the first byte (timeout armed)
  // SEND  | forwarding bytes; also drains an overlong source burst
  // GAP   | enforced idle before the next arbitration
  typedef enum logic [1:0] {IDLE, WAIT, SEND, GAP} state_t;

  localparam logic [15:0] TO_LOAD  = 16'(P_TIMEOUT - 1);
  localparam logic [15:0] GAP_LOAD = 16'(P_GAP - 1);

  state_t      state, state_nx;
  logic        served_ip, served_ip_nx;
  logic        cur_ip, cur_ip_nx;
  logic        drop, drop_nx;
  logic [15:0] byte_cnt, byte_cnt_nx;
  logic [15:0] tmr, tmr_nx;
  logic        arp_grant_nx, ip_grant_nx, mac_req_nx;
  logic [15:0] type_nx, len_nx;
  logic [7:0]  data_nx;
  logic        valid_nx, last_nx, len_err_nx, timeout_nx;
  logic        fwd;
  logic [15:0] cnt_inc;

  logic        win_ip;
  logic [15:0] win_len;
  logic        src_valid, src_last;
  logic [7:0]  src_data;

  // on a tie IP wins only if ARP was served last
  assign win_ip    = i_ip_req & (~i_arp_req | ~served_ip);
  assign win_len   = win_ip ? i_ip_len : i_arp_len;
  assign src_valid = cur_ip ? i_ip_valid : i_arp_valid;
  assign src_last  = cur_ip ? i_ip_last  : i_arp_last;
  assign src_data  = cur_ip ? i_ip_data  : i_arp_data;

  always_comb begin
    state_nx     = state;
    served_ip_nx = served_ip;
    cur_ip_nx    = cur_ip;
    drop_nx      = drop;
    byte_cnt_nx  = byte_cnt;
    tmr_nx       = tmr;
    type_nx      = o_send_type;
    len_nx       = o_send_len;
    arp_grant_nx = 1'b0;
    ip_grant_nx  = 1'b0;
    mac_req_nx   = 1'b0;
    data_nx      = 8'h00;
    valid_nx     = 1'b0;
    last_nx      = 1'b0;
    len_err_nx   = 1'b0;
    timeout_nx   = 1'b0;
    fwd          = 1'b0;
    cnt_inc      = byte_cnt + 16'd1;

    case (state)
      IDLE: begin
        if (i_mac_ready && (i_arp_req || i_ip_req)) begin
          cur_ip_nx    = win_ip;
          served_ip_nx = win_ip;
          type_nx      = win_ip ? 16'h0800 : 16'h0806;
          len_nx       = win_len;
          arp_grant_nx = ~win_ip;
          ip_grant_nx  = win_ip;
          mac_req_nx   = 1'b1;
          byte_cnt_nx  = 16'd0;
          drop_nx      = 1'b0;
          if (win_len == 16'd0) begin
            len_err_nx = 1'b1;
            state_nx   = GAP;
            tmr_nx     = GAP_LOAD;
          end else begin
            state_nx = WAIT;
            tmr_nx   = TO_LOAD;
          end
        end
      end
      WAIT: begin
        if (src_valid) begin
          fwd      = 1'b1;
          state_nx = SEND;
        end else if (tmr == '0) begin
          timeout_nx = 1'b1;
          state_nx   = GAP;
          tmr_nx     = GAP_LOAD;
        end else begin
          tmr_nx = tmr - 16'd1;
        end
      end
      SEND: begin
        if (drop) begin
          if (!src_valid || src_last) begin
            drop_nx  = 1'b0;
            state_nx = GAP;
            tmr_nx   = GAP_LOAD;
          end
        end else if (src_valid) begin
          fwd = 1'b1;
        end
      end
      GAP: begin
        if (tmr == '0) state_nx = IDLE;
        else           tmr_nx   = tmr - 16'd1;
      end
      default: state_nx = IDLE;
    endcase

    // frame ends on whichever of length reached / source last comes first
    if (fwd) begin
      valid_nx    = 1'b1;
      data_nx     = src_data;
      byte_cnt_nx = cnt_inc;
      if (cnt_inc == o_send_len || src_last) begin
        last_nx    = 1'b1;
        len_err_nx = ~(src_last && cnt_inc == o_send_len);
        if (!src_last) begin
          drop_nx  = 1'b1;
          state_nx = SEND;
        end else begin
          state_nx = GAP;
          tmr_nx   = GAP_LOAD;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      served_ip    <= 1'b1;
      cur_ip       <= 1'b0;
      drop         <= 1'b0;
      byte_cnt     <= 16'd0;
      tmr          <= 16'd0;
      o_arp_grant  <= 1'b0;
      o_ip_grant   <= 1'b0;
      o_mac_req    <= 1'b0;
      o_send_type  <= 16'd0;
      o_send_len   <= 16'd0;
      o_send_data  <= 8'd0;
      o_send_valid <= 1'b0;
      o_send_last  <= 1'b0;
      o_len_err    <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_nx;
      served_ip    <= served_ip_nx;
      cur_ip       <= cur_ip_nx;
      drop         <= drop_nx;
      byte_cnt     <= byte_cnt_nx;
      tmr          <= tmr_nx;
      o_arp_grant  <= arp_grant_nx;
      o_ip_grant   <= ip_grant_nx;
      o_mac_req    <= mac_req_nx;
      o_send_type  <= type_nx;
      o_send_len   <= len_nx;
      o_send_data  <= data_nx;
      o_send_valid <= valid_nx;
      o_send_last  <= last_nx;
      o_len_err    <= len_err_nx;
      o_timeout    <= timeout_nx;
    end
  end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: directed frame table plus hand sequences for tie order,
// gap spacing, timeout, backpressure, zero length and mid-frame reset.
module tb_mac_tx_arbiter;
  localparam int GAP = 4;
  localparam int TO  = 1024;

  logic        i_clk, i_rst;
  logic        i_arp_req, i_arp_valid, i_arp_last;
  logic [15:0] i_arp_len;
  logic [7:0]  i_arp_data;
  logic        i_ip_req, i_ip_valid, i_ip_last;
  logic [15:0] i_ip_len;
  logic [7:0]  i_ip_data;
  logic        i_mac_ready;
  logic        o_arp_grant, o_ip_grant, o_mac_req;
  logic [15:0] o_send_type, o_send_len;
  logic [7:0]  o_send_data;
  logic        o_send_valid, o_send_last, o_len_err, o_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mac_tx_arbiter #(.P_GAP(GAP), .P_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_arp_req(i_arp_req), .i_arp_len(i_arp_len), .o_arp_grant(o_arp_grant),
    .i_arp_data(i_arp_data), .i_arp_valid(i_arp_valid), .i_arp_last(i_arp_last),
    .i_ip_req(i_ip_req), .i_ip_len(i_ip_len), .o_ip_grant(o_ip_grant),
    .i_ip_data(i_ip_data), .i_ip_valid(i_ip_valid), .i_ip_last(i_ip_last),
    .o_mac_req(o_mac_req), .i_mac_ready(i_mac_ready),
    .o_send_type(o_send_type), .o_send_len(o_send_len), .o_send_data(o_send_data),
    .o_send_valid(o_send_valid), .o_send_last(o_send_last),
    .o_len_err(o_len_err), .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit ip;
    int len;
    int nbytes;
    int last_at;
    int hole;
    int exp_bytes;
    int exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(input bit exp_ip, input int exp_len, input int bound, output int g);
    bit got;
    got = 1'b0;
    g   = -1;
    for (int k = 0; k < bound && !got; k++) begin
      tick();
      if (o_arp_grant || o_ip_grant) got = 1'b1;
    end
    chk("grant_seen", int'(got), 1);
    if (got) begin
      g = cyc;
      chk("grant_src", int'({o_arp_grant, o_ip_grant}), exp_ip ? 1 : 2);
      chk("mac_req", int'(o_mac_req), 1);
      chk("send_type", int'(o_send_type), exp_ip ? 32'h0800 : 32'h0806);
      chk("send_len", int'(o_send_len), exp_len);
    end
  endtask

  task automatic drive_src(input bit ip, input bit v, input logic [7:0] d, input bit l, input bit noise);
    if (ip) begin
      i_ip_valid = v;  i_ip_data = d;  i_ip_last = l;
      i_arp_valid = noise; i_arp_data = 8'hEE; i_arp_last = noise;
    end else begin
      i_arp_valid = v; i_arp_data = d; i_arp_last = l;
      i_ip_valid = noise; i_ip_data = 8'hEE; i_ip_last = noise;
    end
  endtask

  // source sends nbytes back to back (optional one-cycle hole); the other source
  // drives noise that must be ignored
  task automatic stream(input bit ip, input int nbytes, input int last_at, input int hole,
                        input bit tog, input int seed, input int exp_bytes, input int exp_err,
                        input string tag, output int last_cyc);
    int  sent, outn, last_pos, errs, derr;
    bit  hole_done;
    sent = 0; outn = 0; last_pos = 0; errs = 0; derr = 0; hole_done = 1'b0;
    last_cyc = -1;
    for (int it = 0; it < nbytes + (hole > 0 ? 1 : 0) + 2; it++) begin
      if (sent < nbytes && !(hole > 0 && sent == hole && !hole_done)) begin
        drive_src(ip, 1'b1, 8'(seed + sent), (sent + 1) == last_at, 1'b1);
        sent++;
      end else begin
        if (hole > 0 && sent == hole) hole_done = 1'b1;
        drive_src(ip, 1'b0, 8'h00, 1'b0, 1'b1);
      end
      if (tog) i_mac_ready = ~i_mac_ready;
      tick();
      if (o_send_valid) begin
        outn++;
        if (o_send_data !== 8'(seed + outn - 1)) derr++;
        if (o_send_last) begin
          last_pos = outn;
          last_cyc = cyc;
        end
      end
      if (o_len_err) errs++;
    end
    drive_src(ip, 1'b0, 8'h00, 1'b0, 1'b0);
    i_mac_ready = 1'b1;
    chk({tag, "_bytes"}, outn, exp_bytes);
    chk({tag, "_last_pos"}, last_pos, exp_bytes);
    chk({tag, "_len_err"}, errs, exp_err);
    chk({tag, "_data_errs"}, derr, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g2, l, t, c0, ngr;

    //          ip  len nbytes last hole  exp_bytes exp_err
    vecs[0] = '{1'b0, 28, 28, 28, 0,  28, 0};
    vecs[1] = '{1'b1, 10,  8,  8, 0,   8, 1};
    vecs[2] = '{1'b1, 10, 14, 14, 0,  10, 1};
    vecs[3] = '{1'b1, 60, 60, 60, 30, 60, 0};
    vecs[4] = '{1'b0,  1,  1,  1, 0,   1, 0};
    vecs[5] = '{1'b0,  5,  5,  0, 2,   5, 1};

    i_rst = 1'b1;
    i_arp_req = 0; i_arp_len = 0; i_arp_data = 0; i_arp_valid = 0; i_arp_last = 0;
    i_ip_req  = 0; i_ip_len  = 0; i_ip_data  = 0; i_ip_valid  = 0; i_ip_last  = 0;
    i_mac_ready = 1'b1;
    tick();
    tick();
    chk("reset_outputs", int'(|{o_arp_grant, o_ip_grant, o_mac_req, o_send_type, o_send_len,
        o_send_data, o_send_valid, o_send_last, o_len_err, o_timeout}), 0);
    i_rst = 1'b0;
    tick();

    // simultaneous requests after reset: ARP first, IP P_GAP+1 after ARP's last byte
    i_arp_req = 1; i_arp_len = 16'd28;
    i_ip_req  = 1; i_ip_len  = 16'd60;
    wait_grant(1'b0, 28, 50, g);
    i_arp_req = 0;
    stream(1'b0, 28, 28, 0, 1'b0, 8'h10, 28, 0, "tie_arp", l);
    wait_grant(1'b1, 60, 50, g2);
    chk("tie_ip_grant_spacing", g2 - l, GAP + 1);
    i_ip_req = 0;
    stream(1'b1, 60, 60, 0, 1'b0, 8'h40, 60, 0, "tie_ip", l);
    i_arp_req = 1; i_arp_len = 16'd4;
    i_ip_req  = 1; i_ip_len  = 16'd2;
    wait_grant(1'b0, 4, 50, g);
    i_arp_req = 0;
    stream(1'b0, 4, 4, 0, 1'b0, 8'h70, 4, 0, "tie2_arp", l);
    wait_grant(1'b1, 2, 50, g);
    i_ip_req = 0;
    stream(1'b1, 2, 2, 0, 1'b0, 8'h80, 2, 0, "tie2_ip", l);

    foreach (vecs[i]) begin
      if (vecs[i].ip) begin i_ip_req = 1; i_ip_len = 16'(vecs[i].len); end
      else begin i_arp_req = 1; i_arp_len = 16'(vecs[i].len); end
      wait_grant(vecs[i].ip, vecs[i].len, 50, g);
      i_arp_req = 0; i_ip_req = 0;
      stream(vecs[i].ip, vecs[i].nbytes, vecs[i].last_at, vecs[i].hole, 1'b0, 16 * i + 1,
             vecs[i].exp_bytes, vecs[i].exp_err, $sformatf("vec%0d", i), l);
    end

    // grant timeout, then the pending IP request is served
    i_arp_req = 1; i_arp_len = 16'd5;
    wait_grant(1'b0, 5, 50, g);
    i_arp_req = 0;
    i_ip_req = 1; i_ip_len = 16'd3;
    t = -1;
    for (int k = 0; k < TO + 50 && t < 0; k++) begin
      tick();
      if (o_timeout) t = cyc;
    end
    chk("timeout_latency", t - g, TO);
    wait_grant(1'b1, 3, 50, g2);
    chk("timeout_ip_grant_spacing", g2 - t, GAP + 1);
    i_ip_req = 0;
    stream(1'b1, 3, 3, 0, 1'b0, 8'hA0, 3, 0, "post_to_ip", l);

    // backpressure: nothing granted while not ready, ARP wins the tie after IP
    i_mac_ready = 1'b0;
    i_arp_req = 1; i_arp_len = 16'd6;
    i_ip_req  = 1; i_ip_len  = 16'd4;
    ngr = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (o_arp_grant || o_ip_grant || o_mac_req) ngr++;
    end
    chk("bp_no_grant", ngr, 0);
    i_mac_ready = 1'b1;
    c0 = cyc;
    wait_grant(1'b0, 6, 50, g);
    chk("bp_grant_latency", g - c0, 1);
    i_arp_req = 0;
    stream(1'b0, 6, 6, 0, 1'b1, 8'hB0, 6, 0, "bp_arp", l);
    wait_grant(1'b1, 4, 50, g);
    i_ip_req = 0;
    stream(1'b1, 4, 4, 0, 1'b0, 8'hC0, 4, 0, "bp_ip", l);

    // zero length: error pulse with the grant, nothing forwarded
    i_ip_req = 1; i_ip_len = 16'd0;
    wait_grant(1'b1, 0, 50, g);
    chk("zero_len_err", int'(o_len_err), 1);
    i_ip_req = 0;
    ngr = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_send_valid || o_len_err) ngr++;
    end
    chk("zero_len_quiet", ngr, 0);

    // reset on byte 5 of 20; afterwards ARP wins the tie again
    i_arp_req = 1; i_arp_len = 16'd20;
    wait_grant(1'b0, 20, 50, g);
    i_arp_req = 0;
    for (int k = 0; k < 5; k++) begin
      drive_src(1'b0, 1'b1, 8'(k + 1), 1'b0, 1'b0);
      tick();
    end
    chk("pre_reset_byte5_valid", int'(o_send_valid), 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mid_reset_outputs", int'(|{o_arp_grant, o_ip_grant, o_mac_req, o_send_type, o_send_len,
        o_send_data, o_send_valid, o_send_last, o_len_err, o_timeout}), 0);
    drive_src(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    i_rst = 1'b0;
    i_arp_req = 1; i_arp_len = 16'd20;
    i_ip_req  = 1; i_ip_len  = 16'd9;
    wait_grant(1'b0, 20, 50, g);
    i_arp_req = 0; i_ip_req = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
